// File: rtl/iot_event_serialiser.sv
// iot_event_serialiser
// Synchronises N_DEV asynchronous device status lines, detects on/off
// transitions, buffers them in per-device pending flags and issues them one
// per cycle through a round-robin arbiter.

module iot_event_serialiser #(
  parameter int N_DEV = 8,
  parameter int ID_W  = $clog2(N_DEV)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_DEV-1:0] dev_status,
  input  logic             en,
  output logic             change,
  output logic             on_off,
  output logic [ID_W-1:0]  dev_id,
  output logic             busy
);

  // Synchroniser (s1, s2) and previous-status (s3) stages
  logic [N_DEV-1:0] s1;
  logic [N_DEV-1:0] s2;
  logic [N_DEV-1:0] s3;

  logic [N_DEV-1:0] rise;
  logic [N_DEV-1:0] fall;

  logic [N_DEV-1:0] pending;
  logic [N_DEV-1:0] pend_dir;
  logic [N_DEV-1:0] pending_nxt;
  logic [N_DEV-1:0] pend_dir_nxt;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  cand;
  logic [ID_W-1:0]  grant_idx;
  logic             grant_vld;
  logic [N_DEV-1:0] grant_oh;

  // Two-flop synchroniser followed by the previous-status register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= dev_status;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // Transition detection between the synchronised and previous status
  always_comb begin
    rise = s2 & ~s3;
    fall = ~s2 & s3;
  end

  // Round-robin search for the first pending device after the last grant
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant_oh  = '0;
    cand      = '0;
    if (en) begin
      for (int k = 1; k <= N_DEV; k++) begin
        cand = ID_W'((int'(rr_ptr) + k) % N_DEV);
        if (!grant_vld && pending[cand]) begin
          grant_vld      = 1'b1;
          grant_idx      = cand;
          grant_oh[cand] = 1'b1;
        end
      end
    end
  end

  // Pending flag update: an opposite edge on an un-issued event cancels it,
  // otherwise a new edge queues, otherwise a grant clears the flag
  always_comb begin
    pending_nxt  = pending;
    pend_dir_nxt = pend_dir;
    for (int i = 0; i < N_DEV; i++) begin
      if ((rise[i] | fall[i]) && pending[i] && !grant_oh[i] &&
          (pend_dir[i] != rise[i])) begin
        pending_nxt[i] = 1'b0;
      end else if (rise[i] | fall[i]) begin
        pending_nxt[i]  = 1'b1;
        pend_dir_nxt[i] = rise[i];
      end else if (grant_oh[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Pending state, arbiter pointer and registered event outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending  <= '0;
      pend_dir <= '0;
      rr_ptr   <= ID_W'(N_DEV - 1);
      change   <= 1'b0;
      on_off   <= 1'b0;
      dev_id   <= '0;
      busy     <= 1'b0;
    end else begin
      pending  <= pending_nxt;
      pend_dir <= pend_dir_nxt;
      busy     <= |pending_nxt;
      if (grant_vld) begin
        change <= 1'b1;
        on_off <= pend_dir[grant_idx];
        dev_id <= grant_idx;
        rr_ptr <= grant_idx;
      end else begin
        change <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_iot_event_serialiser.sv
// Testbench for iot_event_serialiser: directed scenarios with literal
// expectations plus randomised traffic checked every cycle against a
// behavioural event-queue model.

module tb_iot_event_serialiser;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] dev_status = '0;
  logic         en = 1'b1;
  logic         change;
  logic         on_off;
  logic [2:0]   dev_id;
  logic         busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit [N-1:0] m_hist [3];     // delay line of sampled status: [0] newest
  bit         m_pend [N];
  bit         m_dir  [N];
  int         m_last;
  bit         m_chg, m_oo, m_busy;
  int         m_id;
  int         net_count;

  iot_event_serialiser #(.N_DEV(8), .ID_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .dev_status (dev_status),
    .en         (en),
    .change     (change),
    .on_off     (on_off),
    .dev_id     (dev_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < 3; j++) m_hist[j] = '0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 1'b0;
      m_dir[i]  = 1'b0;
    end
    m_last = N - 1;
    m_chg = 0; m_oo = 0; m_id = 0; m_busy = 0;
    net_count = 0;
  endtask

  // One clock of the model: the oldest delay-line entry is the last status
  // the device was known to have, the middle one is its current status.
  task automatic model_step(input bit [N-1:0] ds, input bit en_i);
    int g;
    bit [N-1:0] known, now_s;
    known = m_hist[2];
    now_s = m_hist[1];
    g = -1;
    if (en_i) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (m_last + k) % N;
        if (g < 0 && m_pend[j]) g = j;
      end
    end
    if (g >= 0) begin
      m_chg  = 1;
      m_oo   = m_dir[g];
      m_id   = g;
      m_last = g;
    end else begin
      m_chg = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (now_s[i] != known[i]) begin
        if (m_pend[i] && g != i) m_pend[i] = 0;      // on then off: nets to nothing
        else begin
          m_pend[i] = 1;
          m_dir[i]  = now_s[i];
        end
      end else if (g == i) begin
        m_pend[i] = 0;
      end
    end
    m_busy = 0;
    for (int i = 0; i < N; i++) if (m_pend[i]) m_busy = 1;
    m_hist[2] = m_hist[1];
    m_hist[1] = m_hist[0];
    m_hist[0] = ds;
  endtask

  // Model advances on every clock edge and is cleared by the async reset
  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else     model_step(dev_status, en);
    end
  end

  // Compare DUT against the model on every falling edge; tally issued events
  initial begin
    forever begin
      @(negedge clk);
      check("change", int'(change), int'(m_chg));
      check("busy",   int'(busy),   int'(m_busy));
      check("on_off", int'(on_off), int'(m_oo));
      check("dev_id", int'(dev_id), m_id);
      if (!rst && change) net_count += on_off ? 1 : -1;
    end
  end

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    dev_status = '0;
    en = 1'b1;
    tick(3);
    rst = 1'b0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;

    // T1: idle after reset
    for (int c = 0; c < 20; c++) begin
      tick();
      check("t1_change", int'(change), 0);
      check("t1_busy",   int'(busy),   0);
    end

    // T2: single rising event, latency 3 edges after capture
    dev_status = 8'h04;
    tick(3);
    check("t2_early_change", int'(change), 0);
    check("t2_busy_set",     int'(busy),   1);
    tick();
    check("t2_change", int'(change), 1);
    check("t2_on_off", int'(on_off), 1);
    check("t2_dev_id", int'(dev_id), 2);
    check("t2_busy_clr", int'(busy), 0);
    tick();
    check("t2_pulse_end", int'(change), 0);

    // T3: all devices on at once, drained in index order
    do_reset();
    dev_status = 8'hFF;
    tick(3);
    check("t3_early_change", int'(change), 0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("t3_change", int'(change), 1);
      check("t3_on_off", int'(on_off), 1);
      check("t3_dev_id", int'(dev_id), k);
      check("t3_busy",   int'(busy),   (k < 7) ? 1 : 0);
    end
    tick();
    check("t3_done", int'(change), 0);

    // T4: on/off pair buffered while en=0 cancels out
    do_reset();
    en = 1'b0;
    dev_status = 8'h20;
    tick(3);
    check("t4_busy_on", int'(busy), 1);
    dev_status = 8'h00;
    tick(2);
    check("t4_busy_hold", int'(busy), 1);
    tick();
    check("t4_busy_off", int'(busy), 0);
    en = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check("t4_no_change", int'(change), 0);
    end

    // T5: round-robin fairness between dev 1 and dev 6
    do_reset();
    en = 1'b0;
    dev_status = 8'h42;
    tick(4);
    en = 1'b1;
    tick();
    check("t5_first_id", int'(dev_id), 1);
    check("t5_first_chg", int'(change), 1);
    dev_status = 8'h40;
    tick();
    check("t5_second_id", int'(dev_id), 6);
    check("t5_second_chg", int'(change), 1);
    tick(2);
    check("t5_gap_chg", int'(change), 0);
    check("t5_gap_busy", int'(busy), 1);
    tick();
    check("t5_third_chg", int'(change), 1);
    check("t5_third_id",  int'(dev_id), 1);
    check("t5_third_dir", int'(on_off), 0);

    // T6: reset with events pending, devices re-reported afterwards
    do_reset();
    en = 1'b0;
    dev_status = 8'h0F;
    tick(4);
    check("t6_busy_before", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("t6_rst_change", int'(change), 0);
    check("t6_rst_busy",   int'(busy),   0);
    check("t6_rst_id",     int'(dev_id), 0);
    check("t6_rst_onoff",  int'(on_off), 0);
    tick(3);
    rst = 1'b0;
    en = 1'b1;
    tick(3);
    check("t6_early_change", int'(change), 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t6_change", int'(change), 1);
      check("t6_on_off", int'(on_off), 1);
      check("t6_dev_id", int'(dev_id), k);
    end
    tick(2);
    check("t6_done", int'(change), 0);
    check("t6_net",  net_count, 4);

    // Randomised traffic: toggles, bursts and en throttling
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0)
        dev_status = dev_status ^ N'($urandom_range(0, 255));
      en = ($urandom_range(0, 4) != 0);
      tick();
    end
    en = 1'b1;
    tick(40);
    check("rand_drained", int'(busy), 0);
    check("rand_net", net_count, $countones(dev_status));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
